// File: rtl/eight_queen_datapath.sv
// Datapath for an eight-queens backtracking solver. The external controller sequences
// the row/column counters, the per-column row stack, the board image and the safety scan.
module eight_queen_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        rld_en,
  input  logic        row_rst,
  input  logic        rcount_en,
  input  logic        update,
  input  logic        fill_erase,
  input  logic        up_count_en,
  input  logic        down_count_en,
  input  logic        sld_en,
  input  logic        serase,
  input  logic        ccount_rst,
  input  logic        ccount_en,
  input  logic        mld_en,
  output logic        safe_or_not,
  output logic        clm_counter_carry,
  output logic        row_counter_carry,
  output logic        ccarry,
  output logic [63:0] board,
  output logic [23:0] solution,
  output logic        sol_valid
);

  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  ccount_q, ccount_d;
  logic [2:0]  stack_q [8];
  logic [2:0]  stack_d [8];
  logic [7:0]  valid_q, valid_d;
  logic [63:0] board_q, board_d;
  logic        safe_q, safe_d;
  logic [23:0] solution_q, solution_d;
  logic        sol_valid_q, sol_valid_d;

  logic [2:0]  scan_row;
  logic [2:0]  row_dist;
  logic [2:0]  col_dist;
  logic        conflict;

  // Column k = ccount is compared with the candidate (row, col); col_dist is positive while scanning.
  always_comb begin
    scan_row = stack_q[ccount_q];
    row_dist = (scan_row >= row_q) ? (scan_row - row_q) : (row_q - scan_row);
    col_dist = col_q - ccount_q;
    conflict = valid_q[ccount_q] && ((scan_row == row_q) || (row_dist == col_dist));
  end

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    ccount_d    = ccount_q;
    stack_d     = stack_q;
    valid_d     = valid_q;
    board_d     = board_q;
    safe_d      = safe_q;
    solution_d  = solution_q;
    sol_valid_d = sol_valid_q;

    if (row_rst)
      row_d = '0;
    else if (rld_en)
      row_d = valid_q[col_q] ? stack_q[col_q] : '0;
    else if (rcount_en)
      row_d = row_q + 3'd1;

    if (up_count_en && !down_count_en)
      col_d = col_q + 3'd1;
    else if (down_count_en && !up_count_en)
      col_d = col_q - 3'd1;

    if (update)
      board_d[{row_q, col_q}] = fill_erase;

    // Stack data is written even when serase clears the valid bit in the same cycle.
    if (sld_en) begin
      stack_d[col_q] = row_q;
      valid_d[col_q] = 1'b1;
    end
    if (serase)
      valid_d[col_q] = 1'b0;

    if (ccount_rst) begin
      ccount_d = '0;
      safe_d   = 1'b1;
    end else if (ccount_en && (ccount_q < col_q)) begin
      ccount_d = ccount_q + 3'd1;
      if (conflict)
        safe_d = 1'b0;
    end

    if (mld_en) begin
      for (int unsigned i = 0; i < 8; i++)
        solution_d[3*i +: 3] = stack_q[i];
      sol_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      ccount_q    <= '0;
      for (int unsigned i = 0; i < 8; i++)
        stack_q[i] <= '0;
      valid_q     <= '0;
      board_q     <= '0;
      safe_q      <= 1'b1;
      solution_q  <= '0;
      sol_valid_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      ccount_q    <= ccount_d;
      stack_q     <= stack_d;
      valid_q     <= valid_d;
      board_q     <= board_d;
      safe_q      <= safe_d;
      solution_q  <= solution_d;
      sol_valid_q <= sol_valid_d;
    end
  end

  assign safe_or_not       = safe_q;
  assign clm_counter_carry = (col_q == 3'd7);
  assign row_counter_carry = (row_q == 3'd7);
  assign ccarry            = (ccount_q == col_q);
  assign board             = board_q;
  assign solution          = solution_q;
  assign sol_valid         = sol_valid_q;

endmodule

// File: tb/tb_eight_queen_datapath.sv
// Directed bench for eight_queen_datapath: scan results, counter wrap/priority,
// solution capture and reset override, all against hand-computed values.
module tb_eight_queen_datapath;

  logic        clk = 1'b0;
  logic        rst, rld_en, row_rst, rcount_en, update, fill_erase;
  logic        up_count_en, down_count_en, sld_en, serase;
  logic        ccount_rst, ccount_en, mld_en;
  logic        safe_or_not, clm_counter_carry, row_counter_carry, ccarry;
  logic [63:0] board;
  logic [23:0] solution;
  logic        sol_valid;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned tb_col = 0;
  logic [2:0]  sol_rows [8] = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3};
  logic [63:0] exp_board;
  logic [23:0] exp_sol;

  eight_queen_datapath dut (
    .clk(clk), .rst(rst), .rld_en(rld_en), .row_rst(row_rst), .rcount_en(rcount_en),
    .update(update), .fill_erase(fill_erase), .up_count_en(up_count_en),
    .down_count_en(down_count_en), .sld_en(sld_en), .serase(serase),
    .ccount_rst(ccount_rst), .ccount_en(ccount_en), .mld_en(mld_en),
    .safe_or_not(safe_or_not), .clm_counter_carry(clm_counter_carry),
    .row_counter_carry(row_counter_carry), .ccarry(ccarry), .board(board),
    .solution(solution), .sol_valid(sol_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; rld_en = 0; row_rst = 0; rcount_en = 0; update = 0; fill_erase = 0;
    up_count_en = 0; down_count_en = 0; sld_en = 0; serase = 0;
    ccount_rst = 0; ccount_en = 0; mld_en = 0;
  endtask

  // Apply whatever controls are set for exactly one rising edge, then release them.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    rst = 1; tick();
    tb_col = 0;
  endtask

  task automatic set_row(input int unsigned r);
    row_rst = 1; tick();
    for (int unsigned i = 0; i < r; i++) begin
      rcount_en = 1; tick();
    end
  endtask

  task automatic set_col(input int unsigned c);
    while (tb_col != c) begin
      up_count_en = 1; tick();
      tb_col = (tb_col + 1) % 8;
    end
  endtask

  task automatic scan();
    ccount_rst = 1; tick();
    for (int unsigned i = 0; i < tb_col; i++) begin
      ccount_en = 1; tick();
    end
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();
    check("rst_safe", safe_or_not, 1);
    check("rst_ccarry", ccarry, 1);
    check("rst_clm_carry", clm_counter_carry, 0);
    check("rst_row_carry", row_counter_carry, 0);
    check("rst_board", board, 0);
    check("rst_solution", solution, 0);
    check("rst_sol_valid", sol_valid, 0);

    // Queen at (0,0); candidate (2,1) is safe, (1,1) diagonal, (0,1) same row.
    sld_en = 1; tick();
    set_col(1);
    set_row(2);
    scan();
    check("scan1_ccarry", ccarry, 1);
    check("scan1_safe", safe_or_not, 1);
    set_row(1);
    scan();
    check("diag_safe", safe_or_not, 0);
    ccount_en = 1; tick();
    check("hold_safe", safe_or_not, 0);
    check("hold_ccarry", ccarry, 1);
    set_row(0);
    scan();
    check("samerow_safe", safe_or_not, 0);

    // update with row/col moving in the same cycle writes the pre-edge cell (2,1).
    set_row(2);
    update = 1; fill_erase = 1; rcount_en = 1; up_count_en = 1; tick();
    tb_col = 2;
    check("update_preedge", board, 64'h1 << (8*2 + 1));
    check("update_row_moved", dut.row_q, 3);

    // Known solution: every column scans safe against those already placed.
    do_reset();
    exp_board = '0;
    exp_sol = '0;
    for (int unsigned c = 0; c < 8; c++) begin
      set_col(c);
      set_row(sol_rows[c]);
      scan();
      check($sformatf("sol_scan_safe_c%0d", c), safe_or_not, 1);
      check($sformatf("sol_scan_ccarry_c%0d", c), ccarry, 1);
      sld_en = 1; update = 1; fill_erase = 1; tick();
      exp_board[8*sol_rows[c] + c] = 1'b1;
      exp_sol[3*c +: 3] = sol_rows[c];
    end
    check("sol_row_carry", row_counter_carry, 0);
    set_row(7);
    check("row7_carry", row_counter_carry, 1);
    rcount_en = 1; tick();
    check("row_wrap", dut.row_q, 0);
    check("sol_board", board, exp_board);
    check("sol_clm_carry", clm_counter_carry, 1);
    check("presol_valid", sol_valid, 0);
    mld_en = 1; tick();
    check("solution", solution, exp_sol);
    check("sol_valid", sol_valid, 1);

    // Column wrap and up+down hold.
    up_count_en = 1; tick(); tb_col = 0;
    check("col_wrap", dut.col_q, 0);
    check("col_wrap_carry", clm_counter_carry, 0);
    down_count_en = 1; tick(); tb_col = 7;
    check("col_down_wrap", dut.col_q, 7);
    set_col(3);
    up_count_en = 1; down_count_en = 1; tick();
    check("col_hold", dut.col_q, 3);

    // Row priority, backtrack restore, and serase winning over sld_en.
    set_row(5);
    row_rst = 1; rld_en = 1; rcount_en = 1; tick();
    check("row_priority", dut.row_q, 0);
    rld_en = 1; rcount_en = 1; tick();
    check("rld_valid", dut.row_q, 5);
    serase = 1; tick();
    rld_en = 1; tick();
    check("rld_erased", dut.row_q, 0);
    set_row(6);
    sld_en = 1; serase = 1; tick();
    rld_en = 1; tick();
    check("sld_serase", dut.row_q, 0);
    mld_en = 1; tick();
    exp_sol[3*3 +: 3] = 3'd6;
    check("stack_written", solution, exp_sol);

    // Reset in the middle of a scan that has already found a conflict.
    do_reset();
    sld_en = 1; tick();
    set_col(2);
    set_row(0);
    ccount_rst = 1; tick();
    ccount_en = 1; tick();
    check("mid_safe", safe_or_not, 0);
    check("mid_ccarry", ccarry, 0);
    mld_en = 1; tick();
    rst = 1; ccount_en = 1; update = 1; fill_erase = 1; mld_en = 1; tick();
    check("midrst_safe", safe_or_not, 1);
    check("midrst_ccount", dut.ccount_q, 0);
    check("midrst_board", board, 0);
    check("midrst_sol_valid", sol_valid, 0);
    check("midrst_ccarry", ccarry, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eight_queen_datapath.md
EIGHT_QUEEN_DATAPATH -- requirements
Module: eight_queen_datapath

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 rld_en  in  1  load row register from stack[col] (backtrack restore).
REQ-005 row_rst  in  1  clear row register to 0.
REQ-006 rcount_en  in  1  increment row register.
REQ-007 update  in  1  write board cell [row][col].
REQ-008 fill_erase  in  1  value written on update: 1=place queen, 0=erase.
REQ-009 up_count_en / down_count_en  in  1 each  increment / decrement column pointer col.
REQ-010 sld_en  in  1  stack[col] <= row, valid[col] <= 1.
REQ-011 serase  in  1  valid[col] <= 0.
REQ-012 ccount_rst / ccount_en  in  1 each  clear / advance safety-scan counter ccount.
REQ-013 mld_en  in  1  capture solution register.
REQ-014 safe_or_not  out  1  1 = current (row,col) conflicts with no placed queen.
REQ-015 clm_counter_carry  out  1  col == 7.
REQ-016 row_counter_carry  out  1  row == 7.
REQ-017 ccarry  out  1  scan complete: ccount == col.
REQ-018 board  out  64  board[8*r+c] = cell (r,c).
REQ-019 solution  out  24  solution[3*c+:3] = row of queen in column c; sol_valid out 1, high after first mld_en until rst.

Function
REQ-020 State: row[2:0], col[2:0], ccount[2:0], stack[8][2:0], valid[7:0], board[63:0], safe flag, solution[23:0], sol_valid.
REQ-021 Row priority per cycle: row_rst > rld_en > rcount_en; rcount_en at row==7 wraps to 0.
REQ-022 rld_en with valid[col]==0 SHALL load 0.
REQ-023 Col: up_count_en alone increments, down_count_en alone decrements, both together hold; wraps modulo 8.
REQ-024 update, sld_en, serase SHALL use pre-edge row/col values when asserted with row/col changes in the same cycle.
REQ-025 sld_en and serase together: serase wins for valid, stack data still written.
REQ-026 Scan: ccount_rst sets ccount=0 and safe=1 (ccount_rst beats ccount_en).
REQ-027 On ccount_en with ccount<col: k=ccount; conflict if valid[k] and (stack[k]==row or |stack[k]-row| == col-k, 3-bit unsigned differences); conflict clears safe (sticky until ccount_rst); ccount increments.
REQ-028 ccount_en with ccount==col SHALL hold ccount and safe unchanged.
REQ-029 Scan latency: col cycles of ccount_en after ccount_rst; col==0 gives ccarry=1 and safe=1 immediately after ccount_rst.
REQ-030 safe_or_not SHALL be the registered safe flag; meaningful only while ccarry=1; row/col change during scan leaves result undefined (controller responsibility).
REQ-031 clm_counter_carry, row_counter_carry, ccarry SHALL be combinational from registers.
REQ-032 mld_en: solution[3*c+:3] <= stack[c] for all c, sol_valid <= 1, one cycle.

Reset
REQ-033 On rst: row=col=ccount=0, stack=0, valid=0, board=0, solution=0, sol_valid=0, safe=1; outputs after reset: safe_or_not=1, ccarry=1, carries 0.
REQ-034 rst SHALL override every control input in the same cycle, including mid-scan.

Verification
REQ-035 rst, then place stack[0]=0 (sld_en), up_count, row=2, ccount_rst + 1 ccount_en -> ccarry=1, safe_or_not=1.
REQ-036 stack[0]=0, col=1, row=1, scan -> safe_or_not=0 (diagonal); row=0 -> safe_or_not=0 (same row).
REQ-037 Load known solution rows {0,4,7,5,2,6,1,3} col 0..7, scan each col 0..7 -> safe=1 every time; mld_en -> solution=rows packed, sol_valid=1.
REQ-038 up_count_en & down_count_en together at col=3 -> col stays 3; up at col=7 -> col=0, clm_counter_carry drops.
REQ-039 row_rst + rld_en + rcount_en same cycle -> row=0; rld_en with valid[col]=0 after serase -> row=0.
REQ-040 rst asserted mid-scan with safe=0 -> next cycle safe_or_not=1, ccount=0, board=0, sol_valid=0.
